// File: rtl/atm_session_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl_if
// Brief    : Front-panel / provisioning / result bundle for atm_session_ctrl.
// Revision : 1.0
// ============================================================================
interface atm_session_ctrl_if #(
  parameter int CARD_W = 4,
  parameter int AMT_W  = 16,
  parameter int PIN_W  = 16
) ();
  logic              prov_we;
  logic [CARD_W-1:0] prov_card;
  logic [PIN_W-1:0]  prov_pin;
  logic [AMT_W-1:0]  prov_balance;
  logic [AMT_W-1:0]  prov_limit;
  logic              prov_active;
  logic              card_inserted;
  logic [CARD_W-1:0] card_id;
  logic              pin_valid_in;
  logic [PIN_W-1:0]  pin_in;
  logic              op_valid;
  logic [1:0]        op_code;
  logic [AMT_W-1:0]  op_amount;
  logic [PIN_W-1:0]  op_new_pin;
  logic              session_end;
  logic              day_rollover;
  logic [2:0]        state;
  logic              result_valid;
  logic              result_ok;
  logic [2:0]        error_code;
  logic [AMT_W-1:0]  balance_out;
  logic              card_locked;

  modport master (
    output prov_we, prov_card, prov_pin, prov_balance, prov_limit, prov_active,
    output card_inserted, card_id, pin_valid_in, pin_in,
    output op_valid, op_code, op_amount, op_new_pin, session_end, day_rollover,
    input  state, result_valid, result_ok, error_code, balance_out, card_locked
  );

  modport slave (
    input  prov_we, prov_card, prov_pin, prov_balance, prov_limit, prov_active,
    input  card_inserted, card_id, pin_valid_in, pin_in,
    input  op_valid, op_code, op_amount, op_new_pin, session_end, day_rollover,
    output state, result_valid, result_ok, error_code, balance_out, card_locked
  );
endinterface
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Brief    : ATM card session controller with account table, PIN lockout,
//            cumulative daily limits, inactivity timeout and overflow checks.
// Revision : 1.0
// ============================================================================
module atm_session_ctrl #(
  parameter int NUM_CARDS     = 16,
  parameter int CARD_W        = 4,
  parameter int AMT_W         = 16,
  parameter int PIN_W         = 16,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 1000
) (
  input wire                clk,
  input wire                rst_n,
  atm_session_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VALIDATE  = 3'd1,
    S_WAIT_PIN  = 3'd2,
    S_CHECK_PIN = 3'd3,
    S_MENU      = 3'd4,
    S_EXEC      = 3'd5,
    S_RESULT    = 3'd6,
    S_EJECT     = 3'd7
  } state_t;

  localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
  localparam int c_try_w = $clog2(MAX_PIN_TRIES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
  localparam logic [c_try_w-1:0] c_try_last = c_try_w'(MAX_PIN_TRIES - 1);

  localparam logic [2:0] c_err_none    = 3'd0;
  localparam logic [2:0] c_err_card    = 3'd1;
  localparam logic [2:0] c_err_pin     = 3'd2;
  localparam logic [2:0] c_err_insuff  = 3'd3;
  localparam logic [2:0] c_err_limit   = 3'd4;
  localparam logic [2:0] c_err_locked  = 3'd5;
  localparam logic [2:0] c_err_timeout = 3'd6;
  localparam logic [2:0] c_err_ovf     = 3'd7;

  // Account table
  logic [PIN_W-1:0] r_tbl_pin [NUM_CARDS];
  logic [AMT_W-1:0] r_tbl_bal [NUM_CARDS];
  logic [AMT_W-1:0] r_tbl_lim [NUM_CARDS];
  logic [AMT_W-1:0] r_tbl_wd  [NUM_CARDS];
  logic             r_tbl_act [NUM_CARDS];

  state_t             r_state;
  logic [CARD_W-1:0]  r_card;
  logic [PIN_W-1:0]   r_pin_in;
  logic [1:0]         r_op;
  logic [AMT_W-1:0]   r_amt;
  logic [PIN_W-1:0]   r_new_pin;
  logic [c_try_w-1:0] r_tries;
  logic [c_tmo_w-1:0] r_tmo;
  logic [2:0]         r_err;
  logic               r_result_valid;
  logic               r_result_ok;
  logic [AMT_W-1:0]   r_balance_out;
  logic               r_card_locked;

  logic               w_in_range;
  logic               w_prov_in_range;
  logic [PIN_W-1:0]   w_cur_pin;
  logic [AMT_W-1:0]   w_cur_bal;
  logic [AMT_W-1:0]   w_cur_lim;
  logic               w_cur_act;
  logic [AMT_W-1:0]   w_wd_base;
  logic [AMT_W:0]     w_bal_sum;
  logic [AMT_W:0]     w_wd_sum;
  logic [2:0]         w_exec_err;
  logic [AMT_W-1:0]   w_exec_bal;

  assign w_in_range      = 32'(r_card) < NUM_CARDS;
  assign w_prov_in_range = 32'(bus.prov_card) < NUM_CARDS;
  assign w_cur_pin       = r_tbl_pin[r_card];
  assign w_cur_bal       = r_tbl_bal[r_card];
  assign w_cur_lim       = r_tbl_lim[r_card];
  assign w_cur_act       = r_tbl_act[r_card];
  // A rollover landing on the commit edge zeroes the accumulator before this withdraw adds to it.
  assign w_wd_base       = bus.day_rollover ? '0 : r_tbl_wd[r_card];
  assign w_bal_sum       = {1'b0, w_cur_bal} + {1'b0, r_amt};
  assign w_wd_sum        = {1'b0, w_wd_base} + {1'b0, r_amt};

  always_comb begin
    w_exec_err = c_err_none;
    w_exec_bal = w_cur_bal;
    case (r_op)
      2'd1: begin
        if (r_amt != '0) begin
          if (r_amt > w_cur_bal)             w_exec_err = c_err_insuff;
          else if (w_wd_sum > {1'b0, w_cur_lim}) w_exec_err = c_err_limit;
          else                               w_exec_bal = w_cur_bal - r_amt;
        end
      end
      2'd2: begin
        if (w_bal_sum[AMT_W]) w_exec_err = c_err_ovf;
        else                  w_exec_bal = w_bal_sum[AMT_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_card         <= '0;
      r_pin_in       <= '0;
      r_op           <= '0;
      r_amt          <= '0;
      r_new_pin      <= '0;
      r_tries        <= '0;
      r_tmo          <= '0;
      r_err          <= c_err_none;
      r_result_valid <= 1'b0;
      r_result_ok    <= 1'b0;
      r_balance_out  <= '0;
      r_card_locked  <= 1'b0;
      for (int i = 0; i < NUM_CARDS; i++) begin
        r_tbl_pin[i] <= '0;
        r_tbl_bal[i] <= '0;
        r_tbl_lim[i] <= '0;
        r_tbl_wd[i]  <= '0;
        r_tbl_act[i] <= 1'b0;
      end
    end else begin
      r_result_valid <= 1'b0;
      r_result_ok    <= 1'b0;
      if (bus.day_rollover) begin
        for (int i = 0; i < NUM_CARDS; i++) r_tbl_wd[i] <= '0;
      end
      if (r_state != S_IDLE && r_state != S_EJECT && !bus.card_inserted) begin
        r_state <= S_IDLE;
        r_err   <= c_err_none;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.prov_we && w_prov_in_range) begin
              r_tbl_pin[bus.prov_card] <= bus.prov_pin;
              r_tbl_bal[bus.prov_card] <= bus.prov_balance;
              r_tbl_lim[bus.prov_card] <= bus.prov_limit;
              r_tbl_act[bus.prov_card] <= bus.prov_active;
              r_tbl_wd[bus.prov_card]  <= '0;
            end
            if (bus.card_inserted) begin
              r_card        <= bus.card_id;
              r_card_locked <= 1'b0;
              r_err         <= c_err_none;
              r_state       <= S_VALIDATE;
            end
          end
          S_VALIDATE: begin
            if (!w_in_range || !w_cur_act) begin
              r_err          <= c_err_card;
              r_result_valid <= 1'b1;
              r_state        <= S_EJECT;
            end else begin
              r_tries <= '0;
              r_tmo   <= '0;
              r_state <= S_WAIT_PIN;
            end
          end
          S_WAIT_PIN: begin
            if (bus.pin_valid_in) begin
              r_pin_in <= bus.pin_in;
              r_state  <= S_CHECK_PIN;
            end else if (r_tmo == c_tmo_last) begin
              r_err          <= c_err_timeout;
              r_result_valid <= 1'b1;
              r_state        <= S_EJECT;
            end else begin
              r_tmo <= r_tmo + c_tmo_w'(1);
            end
          end
          S_CHECK_PIN: begin
            if (r_pin_in == w_cur_pin) begin
              r_tries <= '0;
              r_tmo   <= '0;
              r_err   <= c_err_none;
              r_state <= S_MENU;
            end else if (r_tries == c_try_last) begin
              r_tbl_act[r_card] <= 1'b0;
              r_card_locked     <= 1'b1;
              r_err             <= c_err_locked;
              r_result_valid    <= 1'b1;
              r_state           <= S_EJECT;
            end else begin
              r_tries        <= r_tries + c_try_w'(1);
              r_err          <= c_err_pin;
              r_result_valid <= 1'b1;
              r_tmo          <= '0;
              r_state        <= S_WAIT_PIN;
            end
          end
          S_MENU: begin
            if (bus.op_valid) begin
              r_op      <= bus.op_code;
              r_amt     <= bus.op_amount;
              r_new_pin <= bus.op_new_pin;
              r_state   <= S_EXEC;
            end else if (bus.session_end) begin
              r_err          <= c_err_none;
              r_result_valid <= 1'b1;
              r_result_ok    <= 1'b1;
              r_state        <= S_EJECT;
            end else if (r_tmo == c_tmo_last) begin
              r_err          <= c_err_timeout;
              r_result_valid <= 1'b1;
              r_state        <= S_EJECT;
            end else begin
              r_tmo <= r_tmo + c_tmo_w'(1);
            end
          end
          S_EXEC: begin
            // Result outputs are registered here so they are visible during RESULT.
            r_err          <= w_exec_err;
            r_result_valid <= 1'b1;
            r_result_ok    <= (w_exec_err == c_err_none);
            r_balance_out  <= w_exec_bal;
            r_state        <= S_RESULT;
            if (w_exec_err == c_err_none) begin
              case (r_op)
                2'd1: begin
                  r_tbl_bal[r_card] <= w_exec_bal;
                  r_tbl_wd[r_card]  <= w_wd_sum[AMT_W-1:0];
                end
                2'd2: r_tbl_bal[r_card] <= w_exec_bal;
                2'd3: r_tbl_pin[r_card] <= r_new_pin;
                default: ;
              endcase
            end
          end
          S_RESULT: begin
            r_tmo   <= '0;
            r_state <= S_MENU;
          end
          S_EJECT: begin
            if (!bus.card_inserted) begin
              r_err   <= c_err_none;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.state        = r_state;
  assign bus.result_valid = r_result_valid;
  assign bus.result_ok    = r_result_ok;
  assign bus.error_code   = r_err;
  assign bus.balance_out  = r_balance_out;
  assign bus.card_locked  = r_card_locked;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_session_ctrl
// Brief    : Scoreboard bench for atm_session_ctrl sessions and error paths.
// Revision : 1.0
// ============================================================================
module tb_atm_session_ctrl;

  localparam int NC   = 12;
  localparam int TMO  = 64;
  localparam int MAXT = 3;

  typedef struct packed {
    logic        ok;
    logic [2:0]  err;
    logic        chk_bal;
    logic [15:0] bal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atm_session_ctrl_if #(.CARD_W(4), .AMT_W(16), .PIN_W(16)) bus ();

  atm_session_ctrl #(
    .NUM_CARDS(NC), .CARD_W(4), .AMT_W(16), .PIN_W(16),
    .MAX_PIN_TRIES(MAXT), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  logic [15:0] m_pin [16];
  logic [15:0] m_bal [16];
  logic [15:0] m_lim [16];
  logic [15:0] m_wd  [16];
  logic        m_act [16];
  int m_tries;
  int cur;

  function automatic exp_t mk(input logic ok, input logic [2:0] err,
                              input logic chk, input logic [15:0] bal);
    exp_t e;
    e.ok = ok; e.err = err; e.chk_bal = chk; e.bal = bal;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.result_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: result_valid with nothing expected, err=%0d", bus.error_code);
      end else begin
        mon_e = sb.pop_front();
        if (bus.result_ok !== mon_e.ok || bus.error_code !== mon_e.err ||
            (mon_e.chk_bal && bus.balance_out !== mon_e.bal)) begin
          fails++;
          $display("FAIL result: got ok=%b err=%0d bal=%h, expected ok=%b err=%0d bal=%h",
                   bus.result_ok, bus.error_code, bus.balance_out, mon_e.ok, mon_e.err, mon_e.bal);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    tests++;
    if (bus.state !== exp) begin
      fails++;
      $display("FAIL %s: state=%0d expected=%0d", name, bus.state, exp);
    end
  endtask

  task automatic prov(input int card, input logic [15:0] pin, input logic [15:0] bal,
                      input logic [15:0] lim, input logic act);
    bus.prov_we = 1'b1; bus.prov_card = 4'(card); bus.prov_pin = pin;
    bus.prov_balance = bal; bus.prov_limit = lim; bus.prov_active = act;
    tick();
    bus.prov_we = 1'b0;
    m_pin[card] = pin; m_bal[card] = bal; m_lim[card] = lim; m_wd[card] = '0; m_act[card] = act;
  endtask

  task automatic insert(input int card);
    bit bad;
    bad = (card >= NC) || !m_act[card];
    cur = card;
    m_tries = 0;
    if (bad) sb.push_back(mk(1'b0, 3'd1, 1'b0, 16'h0));
    bus.card_id = 4'(card);
    bus.card_inserted = 1'b1;
    tick();
    tick();
    check_state("insert_state", bad ? 3'd7 : 3'd2);
    tests++;
    if (bus.card_locked !== 1'b0) begin
      fails++;
      $display("FAIL insert_locked_clear: card_locked=%b expected=0", bus.card_locked);
    end
  endtask

  task automatic remove();
    bus.card_inserted = 1'b0;
    tick();
    check_state("remove_idle", 3'd0);
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    logic [2:0] exp_state;
    bus.pin_in = pin;
    bus.pin_valid_in = 1'b1;
    tick();
    bus.pin_valid_in = 1'b0;
    if (pin == m_pin[cur]) begin
      m_tries = 0;
      exp_state = 3'd4;
    end else begin
      m_tries++;
      if (m_tries >= MAXT) begin
        sb.push_back(mk(1'b0, 3'd5, 1'b0, 16'h0));
        m_act[cur] = 1'b0;
        exp_state = 3'd7;
      end else begin
        sb.push_back(mk(1'b0, 3'd2, 1'b0, 16'h0));
        exp_state = 3'd2;
      end
    end
    tick();
    check_state("pin_next_state", exp_state);
    if (exp_state == 3'd7) begin
      tests++;
      if (bus.card_locked !== 1'b1 || bus.error_code !== 3'd5) begin
        fails++;
        $display("FAIL lockout: card_locked=%b err=%0d expected 1/5", bus.card_locked, bus.error_code);
      end
    end
  endtask

  task automatic wait_menu();
    int n = 0;
    while (bus.state !== 3'd4 && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [1:0] code, input int amt, input logic [15:0] newpin,
                       input bit roll_in_exec);
    logic [2:0] err;
    int bal;
    wait_menu();
    if (roll_in_exec) for (int i = 0; i < 16; i++) m_wd[i] = '0;
    err = 3'd0;
    bal = int'(m_bal[cur]);
    case (code)
      2'd1: if (amt != 0) begin
        if (amt > bal) err = 3'd3;
        else if (int'(m_wd[cur]) + amt > int'(m_lim[cur])) err = 3'd4;
        else begin
          bal = bal - amt;
          m_wd[cur] = 16'(int'(m_wd[cur]) + amt);
        end
      end
      2'd2: if (bal + amt > 32'hFFFF) err = 3'd7; else bal = bal + amt;
      2'd3: m_pin[cur] = newpin;
      default: ;
    endcase
    if (err == 3'd0) m_bal[cur] = 16'(bal);
    sb.push_back(mk(err == 3'd0, err, 1'b1, m_bal[cur]));
    bus.op_code = code; bus.op_amount = 16'(amt); bus.op_new_pin = newpin;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    if (roll_in_exec) bus.day_rollover = 1'b1;
    tests++;
    if (bus.state !== 3'd5 || bus.result_valid !== 1'b0) begin
      fails++;
      $display("FAIL op_latency_n1: state=%0d result_valid=%b expected 5/0", bus.state, bus.result_valid);
    end
    tick();
    bus.day_rollover = 1'b0;
    tests++;
    if (bus.result_valid !== 1'b1) begin
      fails++;
      $display("FAIL op_latency_n2: result_valid=%b expected=1", bus.result_valid);
    end
  endtask

  task automatic rollover();
    bus.day_rollover = 1'b1;
    tick();
    bus.day_rollover = 1'b0;
    for (int i = 0; i < 16; i++) m_wd[i] = '0;
  endtask

  task automatic end_session();
    wait_menu();
    sb.push_back(mk(1'b1, 3'd0, 1'b0, 16'h0));
    bus.session_end = 1'b1;
    tick();
    bus.session_end = 1'b0;
    check_state("end_session_eject", 3'd7);
    remove();
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if (bus.state !== 3'd0 || bus.result_valid !== 1'b0 || bus.result_ok !== 1'b0 ||
        bus.error_code !== 3'd0 || bus.balance_out !== 16'h0 || bus.card_locked !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: state=%0d rv=%b ok=%b err=%0d bal=%h lk=%b expected all 0",
               bus.state, bus.result_valid, bus.result_ok, bus.error_code, bus.balance_out, bus.card_locked);
    end
    rst_n = 1'b1;
    tick();
    insert(0);
    remove();
  endtask

  task automatic test_withdraw_limit();
    prov(3, 16'h1234, 16'd500, 16'd300, 1'b1);
    insert(3);
    enter_pin(16'h1234);
    do_op(2'd1, 200, 16'h0, 1'b0);
    do_op(2'd1, 150, 16'h0, 1'b0);
    wait_menu();
    rollover();
    do_op(2'd1, 150, 16'h0, 1'b0);
    end_session();
  endtask

  task automatic test_lockout();
    insert(3);
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    enter_pin(16'h3333);
    remove();
    insert(3);
    remove();
  endtask

  task automatic test_overflow_timeout();
    int n = 0;
    prov(5, 16'h5555, 16'hFFF0, 16'hFFFF, 1'b1);
    insert(5);
    enter_pin(16'h5555);
    do_op(2'd2, 32'h20, 16'h0, 1'b0);
    do_op(2'd1, 32'hFFF1, 16'h0, 1'b0);
    do_op(2'd2, 32'h0F, 16'h0, 1'b0);
    do_op(2'd0, 0, 16'h0, 1'b0);
    do_op(2'd1, 0, 16'h0, 1'b0);
    sb.push_back(mk(1'b0, 3'd6, 1'b0, 16'h0));
    while (bus.state !== 3'd7 && n < 3 * TMO) begin
      tick();
      n++;
    end
    tests++;
    if (n != TMO + 1 || bus.error_code !== 3'd6) begin
      fails++;
      $display("FAIL menu_timeout: cycles=%0d err=%0d expected %0d/6", n, bus.error_code, TMO + 1);
    end
    remove();
  endtask

  task automatic test_removal_prov_pinchange();
    insert(5);
    enter_pin(16'h5555);
    bus.op_code = 2'd1; bus.op_amount = 16'd100; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.card_inserted = 1'b0;
    tick();
    tests++;
    if (bus.state !== 3'd0 || bus.result_valid !== 1'b0) begin
      fails++;
      $display("FAIL removal_in_exec: state=%0d rv=%b expected 0/0", bus.state, bus.result_valid);
    end
    insert(5);
    enter_pin(16'h5555);
    do_op(2'd0, 0, 16'h0, 1'b0);
    bus.prov_we = 1'b1; bus.prov_card = 4'd5; bus.prov_balance = 16'd7;
    bus.prov_active = 1'b0; bus.prov_pin = 16'h0;
    tick();
    bus.prov_we = 1'b0;
    do_op(2'd0, 0, 16'h0, 1'b0);
    do_op(2'd3, 0, 16'hBEEF, 1'b0);
    end_session();
    insert(5);
    enter_pin(16'hBEEF);
    end_session();
  endtask

  task automatic test_invalid_cards();
    insert(9);
    remove();
    insert(13);
    remove();
  endtask

  task automatic test_back_to_back();
    bus.card_id = 4'd9;
    bus.card_inserted = 1'b1;
    prov(9, 16'h0909, 16'd10, 16'd10, 1'b1);
    cur = 9;
    m_tries = 0;
    tick();
    check_state("prov_with_insert", 3'd2);
    enter_pin(16'h0909);
    do_op(2'd1, 11, 16'h0, 1'b0);
    do_op(2'd1, 10, 16'h0, 1'b0);
    do_op(2'd2, 5, 16'h0, 1'b0);
    do_op(2'd1, 1, 16'h0, 1'b0);
    do_op(2'd1, 3, 16'h0, 1'b1);
    end_session();
  endtask

  initial begin
    bus.prov_we = 1'b0; bus.prov_card = '0; bus.prov_pin = '0; bus.prov_balance = '0;
    bus.prov_limit = '0; bus.prov_active = 1'b0; bus.card_inserted = 1'b0; bus.card_id = '0;
    bus.pin_valid_in = 1'b0; bus.pin_in = '0; bus.op_valid = 1'b0; bus.op_code = '0;
    bus.op_amount = '0; bus.op_new_pin = '0; bus.session_end = 1'b0; bus.day_rollover = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_pin[i] = '0; m_bal[i] = '0; m_lim[i] = '0; m_wd[i] = '0; m_act[i] = 1'b0;
    end
    m_tries = 0;
    cur = 0;
    test_reset();
    test_withdraw_limit();
    test_lockout();
    test_overflow_timeout();
    test_removal_prov_pinchange();
    test_invalid_cards();
    test_back_to_back();
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results never seen, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised, second-generation ATM session controller. It holds an internal table of NUM_CARDS accounts, each with PIN, balance, daily limit, withdrawn-today accumulator and active flag. The block runs a full card session: validate, PIN with lockout, menu, then balance/withdraw/deposit/PIN-change. Additions over the first generation: runtime provisioning, persistent card lockout, cumulative daily limit with day rollover, session inactivity timeout, and deposit overflow detection. It sits between the front-panel input decoder and the display/receipt logic.

Parameters:
NUM_CARDS, 16, number of account entries
CARD_W, 4, card index width (clog2 NUM_CARDS)
AMT_W, 16, balance/amount/limit width
PIN_W, 16, PIN width
MAX_PIN_TRIES, 3, consecutive wrong PINs before lockout
TIMEOUT_CYC, 1000, idle cycles in WAIT_PIN/MENU before forced eject

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
prov_we  in  1  provisioning write strobe, honoured only in IDLE
prov_card  in  CARD_W  entry to write
prov_pin / prov_balance / prov_limit  in  PIN_W/AMT_W/AMT_W  entry contents
prov_active  in  1  active flag; also clears withdrawn-today for that entry
card_inserted  in  1  level, card present
card_id  in  CARD_W  sampled on IDLE->VALIDATE
pin_valid_in  in  1  PIN entry strobe
pin_in  in  PIN_W  entered PIN
op_valid  in  1  operation request strobe, accepted in MENU only
op_code  in  2  0 balance, 1 withdraw, 2 deposit, 3 PIN change
op_amount  in  AMT_W  amount for withdraw/deposit
op_new_pin  in  PIN_W  new PIN for op 3
session_end  in  1  user ends session from MENU
day_rollover  in  1  pulse, clears all withdrawn-today accumulators
state  out  3  current state encoding
result_valid  out  1  one-cycle pulse per completed event
result_ok  out  1  qualifies result_valid
error_code  out  3  0 none, 1 invalid card, 2 wrong PIN, 3 insufficient, 4 limit, 5 locked, 6 timeout, 7 overflow
balance_out  out  AMT_W  balance of session card after last op
card_locked  out  1  session card was locked this session

Behaviour:
- Reset: state=IDLE; all outputs 0; all table fields 0, all entries inactive. Mid-session reset aborts with no commit.
- States: IDLE(0), VALIDATE(1), WAIT_PIN(2), CHECK_PIN(3), MENU(4), EXEC(5), RESULT(6), EJECT(7).
- IDLE: card_inserted=1 -> latch card_id, VALIDATE. An index >= NUM_CARDS is invalid.
- VALIDATE (1 cycle): an inactive or out-of-range entry -> EJECT, error 1, result_valid. Otherwise WAIT_PIN with tries=0.
- WAIT_PIN: pin_valid_in -> latch pin_in, CHECK_PIN.
- CHECK_PIN (1 cycle): on a match, tries=0 and go to MENU. On a mismatch, tries+1 with error 2 and result_valid; if tries reaches MAX_PIN_TRIES, clear the entry active flag, set card_locked, error 5, EJECT; else back to WAIT_PIN.
- MENU: op_valid -> latch op, EXEC; session_end -> EJECT with error 0; op_valid has priority when both are asserted.
- EXEC (1 cycle) computes in AMT_W+1 bits; commits take effect at the EXEC->RESULT edge.
  - Withdraw: fail 3 if amount>balance. Else fail 4 if withdrawn+amount>limit. Else balance-=amount, withdrawn+=amount. Error 3 takes priority over 4.
  - Deposit: fail 7 if balance+amount overflows AMT_W, with no change.
  - Balance: no change.
  - PIN change: pin=op_new_pin.
  - Amount 0 always succeeds.
- RESULT (1 cycle): result_valid=1, result_ok=(error==0), balance_out updated, -> MENU. Latency is op_valid accepted at cycle N, result_valid at N+2.
- EJECT: hold error; result_valid pulsed on entry only; card_inserted=0 -> IDLE, error cleared.
- Card removal (card_inserted=0) in any state other than IDLE/EJECT -> IDLE next cycle, no commit, no result.
- Timeout: counter resets on entering WAIT_PIN/MENU and on any pin_valid_in/op_valid. Reaching TIMEOUT_CYC -> EJECT, error 6.
- day_rollover is accepted in any state. When it coincides with a withdraw commit, rollover applies first, so withdrawn=amount.
- prov_we outside IDLE is ignored. prov_we coinciding with card_inserted in IDLE: the write lands and the session sees the new entry.

Test Plan:
- Provision card 3 (pin 0x1234, bal 500, limit 300, active), insert, PIN 0x1234, withdraw 200 -> result_ok, balance_out=300, result_valid 2 cycles after op_valid.
- Same card: withdraw 150 -> error 4 (cumulative 350>300); day_rollover, withdraw 150 -> ok, balance_out=150.
- Three wrong PINs -> error 2 twice, then error 5, card_locked=1, EJECT. Reinsert card 3 -> error 1.
- bal 0xFFF0, deposit 0x20 -> error 7, balance unchanged. Then withdraw 0xFFF1 -> error 3.
- In MENU, idle TIMEOUT_CYC cycles -> EJECT, error 6. Card removal during EXEC -> IDLE, balance unchanged.
- Inactive card 9 and card_id beyond NUM_CARDS -> error 1. prov_we during MENU -> table unchanged.
